add_seq: RTL and testbench
==========================

Name: add_seq

Overview:
- Parametrised, multi-cycle chunk-serial adder/subtractor.
- Generalises the fixed 4-bit combinational add_4: operand width is a parameter, and the operation runs CHUNK bits per clock under a start/busy/done handshake.
- Adds subtract mode and a signed-overflow flag.
- Used where wide additions must share one narrow carry chain across several cycles.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits processed per clock. N = WIDTH/CHUNK cycles per operation. CHUNK = WIDTH is legal and gives single-cycle operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0 = add, 1 = subtract; latched with start
- in_0  input  WIDTH  operand A; latched with start
- in_1  input  WIDTH  operand B; latched with start
- cin  input  1  carry-in (add) or borrow-in (sub); latched with start
- out  output  WIDTH  result; held between operations
- cout  output  1  raw carry out of the MSB
- ovf  output  1  signed overflow of the result
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset: async assert of rst_n clears out=0, cout=0, ovf=0, busy=0, done=0, state=IDLE, chunk counter=0 and internal operand/partial registers. Operation resumes on the first clk edge after rst_n deasserts.
- States: IDLE and RUN.
- IDLE:
  - start=1 at an edge: latch A=in_0.
  - Latch B = in_1 when sub=0, ~in_1 when sub=1.
  - Latch carry c = cin when sub=0, ~cin when sub=1.
  - Clear chunk counter; go to RUN; busy=1 after that edge.
- Effective arithmetic: out = A + B + c, modulo 2^WIDTH.
  - Subtract gives in_0 - in_1 - cin.
  - cout is the raw final carry; in subtract mode cout=0 means a borrow occurred.
- RUN, each edge:
  - Add chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1, LSB chunk first) of A and B plus the carry register.
  - Store the chunk sum in the internal result register; update the carry register; i increments.
- Last chunk (i = N-1), at the same edge:
  - out <= full result; cout <= final carry.
  - ovf <= carry into MSB XOR carry out of MSB.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: start sampled at edge k; done=1 and valid out/cout/ovf appear after edge k+N.
- done is high for exactly one cycle.
- out/cout/ovf change only at completion. They do not change during RUN and hold until the next completion.
- start while busy=1 is ignored: no effect on latched operands, no queuing.
- start in the cycle where done=1 is accepted, since state is already IDLE. Back-to-back operations therefore have throughput of one per N cycles.
- sub, in_0, in_1 and cin may change freely during RUN without effect.
- Reset mid-RUN: operation is aborted, outputs cleared, and no done is issued.
- CHUNK=WIDTH: N=1, so done follows the start edge by one clock.

Test Plan:
- Add, WIDTH=16, CHUNK=4: in_0=0x1234, in_1=0x0FF1, cin=0, sub=0, start pulse -> busy high for 4 cycles, then done pulse with out=0x2225, cout=0, ovf=0.
- Carry/overflow:
  - 0xFFFF+0x0001, cin=0 -> out=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> out=0x8000, cout=0, ovf=1.
  - 0x0000+0x0000, cin=1 -> out=0x0001.
- Subtract: in_0=0x0005, in_1=0x0007, cin=0, sub=1 -> out=0xFFFE, cout=0, ovf=0. Then 0x8000-0x0001 -> out=0x7FFF, cout=1, ovf=1.
- Handshake:
  - start again with other operands while busy -> ignored; first result unchanged.
  - start asserted in the done cycle -> accepted; second done exactly 4 cycles later; out unchanged in between.
- Reset: drop rst_n asynchronously mid-clock during the 2nd RUN cycle -> out, cout, ovf, busy, done go to 0 immediately, no done follows. A fresh start after release completes normally.
- Parameter sweep: CHUNK=16 and CHUNK=1 with WIDTH=16; 1000 random operand/sub/cin sets each -> result matches a reference model. Latency is 1 and 16 cycles respectively.

Source files
------------

// File: rtl/add_seq.sv
// add_seq: chunk-serial adder/subtractor.
// A WIDTH-bit add or subtract is spread over N = WIDTH/CHUNK clocks.
// Each clock pushes one CHUNK-bit slice, LSB slice first, through a single
// narrow carry chain. The carry is kept in a register between slices.
// Subtraction is done as A + ~B + ~cin, so the same chain serves both modes.
// out/cout/ovf are updated only when the last slice completes.
module add_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_chk;
  logic [CHUNK:0]   sum_chk;
  logic             msb_cin;
  logic [WIDTH-1:0] res_ins;

  // Select the current operand slices and merge the new sum slice into the result.
  always_comb begin
    a_chk   = '0;
    b_chk   = '0;
    res_ins = res_q;
    for (int j = 0; j < N; j++) begin
      if (cnt_q == CNT_W'(j)) begin
        a_chk = a_q[j*CHUNK +: CHUNK];
        b_chk = b_q[j*CHUNK +: CHUNK];
        res_ins[j*CHUNK +: CHUNK] = sum_chk[CHUNK-1:0];
      end
    end
  end

  // The shared narrow carry chain. The carry into the slice MSB is recovered
  // from the MSB sum bit. On the last slice this is the carry into the word
  // MSB, which gives the signed-overflow flag.
  always_comb begin
    sum_chk = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, c_q};
    msb_cin = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ sum_chk[CHUNK-1];
  end

  // Next-state logic for the IDLE/RUN sequencer and its registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    out_d   = out_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_0;
          b_d     = sub ? ~in_1 : in_1;
          c_d     = cin ^ sub;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_ins;
        c_d   = sum_chk[CHUNK];
        if (cnt_q == LAST) begin
          out_d   = res_ins;
          cout_d  = sum_chk[CHUNK];
          ovf_d   = msb_cin ^ sum_chk[CHUNK];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state, with asynchronous clear that aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_add_seq.sv
// Testbench for add_seq: directed vector table on a WIDTH=16/CHUNK=4 instance,
// handshake and reset sequences, then a random sweep that runs CHUNK=16,
// CHUNK=4 and CHUNK=1 instances side by side on shared inputs.
module tb_add_seq;
  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] in_0  = '0;
  logic [W-1:0] in_1  = '0;

  logic [W-1:0] o1, o4, o16;
  logic         co1, co4, co16;
  logic         ov1, ov4, ov16;
  logic         b1, b4, b16;
  logic         d1, d4, d16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] exp_out;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  add_seq #(.WIDTH(W), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .in_0(in_0), .in_1(in_1),
    .cin(cin), .out(o4), .cout(co4), .ovf(ov4), .busy(b4), .done(d4));

  add_seq #(.WIDTH(W), .CHUNK(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .in_0(in_0), .in_1(in_1),
    .cin(cin), .out(o1), .cout(co1), .ovf(ov1), .busy(b1), .done(d1));

  add_seq #(.WIDTH(W), .CHUNK(1)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .in_0(in_0), .in_1(in_1),
    .cin(cin), .out(o16), .cout(co16), .ovf(ov16), .busy(b16), .done(d16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start one operation at the current negedge on the CHUNK=4 instance and
  // return at the negedge where done is seen; lat counts edges after the start edge.
  task automatic run4(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, output int lat);
    logic [W-1:0] held;
    held  = o4;
    in_0  = a;
    in_1  = b;
    cin   = ci;
    sub   = sb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_in_run", 32'(b4), 32'd1);
    lat = 0;
    while (!d4 && lat < 40) begin
      check("out_held", 32'(o4), 32'(held));
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(d4), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [W-1:0] a, b, bb, r;
    logic         ci, sb, cc, co, ov;
    logic [W:0]   full;
    logic         bad1, bad4, bad16, saw_done;

    vecs[0] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", 32'(o4), 32'd0);
    check("rst_flags", {29'd0, co4, ov4, b4}, 32'd0);
    check("rst_done", 32'(d4), 32'd0);
    check("rst_busy_other", {30'd0, b1, b16}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      run4(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_out", i), 32'(o4), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_cout", i), 32'(co4), 32'(vecs[i].exp_cout));
      check($sformatf("v%0d_ovf", i), 32'(ov4), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(d4), 32'd0);
    end

    // start while busy is ignored
    in_0 = 16'h1111; in_1 = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    in_0 = 16'hAAAA; in_1 = 16'h5555; cin = 1'b1; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!d4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("busy_ign_lat", 32'(lat), 32'd4);
    check("busy_ign_out", 32'(o4), 32'h3333);
    check("busy_ign_flags", {30'd0, co4, ov4}, 32'd0);
    @(negedge clk);
    check("busy_ign_idle", {30'd0, b4, d4}, 32'd0);

    // start in the done cycle is accepted; out holds until the second done
    run4(16'h0100, 16'h0023, 1'b0, 1'b0, lat);
    check("b2b_first_out", 32'(o4), 32'h0123);
    run4(16'h4000, 16'h4000, 1'b0, 1'b0, lat);
    check("b2b_second_lat", 32'(lat), 32'd4);
    check("b2b_second_out", 32'(o4), 32'h8000);
    check("b2b_second_flags", {30'd0, co4, ov4}, 32'd1);

    // Asynchronous reset during the second RUN cycle
    @(negedge clk);
    in_0 = 16'h0F0F; in_1 = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(o4), 32'd0);
    check("mid_rst_flags", {29'd0, co4, ov4, b4}, 32'd0);
    check("mid_rst_done", 32'(d4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d4 || b4) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    run4(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_out", 32'(o4), 32'h1010);

    // Bring every instance back to IDLE before the sweep
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random sweep: CHUNK=16 done at c=2, CHUNK=4 at c=5, CHUNK=1 at c=17
    for (int it = 0; it < 1000; it++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      bb = sb ? ~b : b;
      cc = ci ^ sb;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
      r  = full[W-1:0];
      co = full[W];
      ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      in_0 = a; in_1 = b; cin = ci; sub = sb; start = 1'b1;
      bad1 = 1'b0; bad4 = 1'b0; bad16 = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
        if (d1 != (c == 2)) bad1 = 1'b1;
        if (d4 != (c == 5)) bad4 = 1'b1;
        if (d16 != (c == 17)) bad16 = 1'b1;
        if (c == 2) check($sformatf("sw%0d_c16_res", it), {15'd0, co1, ov1, o1}, {15'd0, co, ov, r});
        if (c == 5) check($sformatf("sw%0d_c4_res", it), {15'd0, co4, ov4, o4}, {15'd0, co, ov, r});
        if (c == 17) check($sformatf("sw%0d_c1_res", it), {15'd0, co16, ov16, o16}, {15'd0, co, ov, r});
      end
      check($sformatf("sw%0d_c16_lat", it), 32'(bad1), 32'd0);
      check($sformatf("sw%0d_c4_lat", it), 32'(bad4), 32'd0);
      check($sformatf("sw%0d_c1_lat", it), 32'(bad16), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
